// File: rtl/sampler_axi4_mem_slave.sv
// AXI4 burst memory slave: independent one-outstanding write and read engines over a word-addressed RAM.
// AW->WREADY 1 cycle, last W->BVALID 1 cycle, AR->RVALID 2 cycles; BVALID/RVALID hold until BREADY/RREADY.
module sampler_axi4_mem_slave #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 10
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);
    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int WORDS = 1 << (AW - 2);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_LOAD, R_DATA} r_state_t;

    // Legal WRAP lengths make the window mask simply {len, 2'b11}.
    function automatic logic [AW-1:0] f_next_addr(input logic [AW-1:0] addr,
                                                   input logic [1:0]    burst,
                                                   input logic [7:0]    len);
        logic [AW-1:0] mask;
        mask = AW'({len[3:0], 2'b11});
        case (burst)
            BURST_FIXED: return addr;
            BURST_WRAP:  return (addr & ~mask) | ((addr + AW'(4)) & mask);
            default:     return addr + AW'(4);
        endcase
    endfunction

    function automatic logic f_cfg_err(input logic [2:0] size,
                                       input logic [1:0] burst,
                                       input logic [7:0] len);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size != 3'd2) || (burst == 2'b11) || ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

    logic [DW-1:0] r_mem [WORDS];

    w_state_t                    r_wstate;
    logic [AW-1:0]               r_waddr;
    logic [7:0]                  r_wlen;
    logic [7:0]                  r_wcnt;
    logic [1:0]                  r_wburst;
    logic                        r_wcfg_err;
    logic                        r_wlast_err;
    logic                        r_awready;
    logic                        r_wready;
    logic                        r_bvalid;
    logic [1:0]                  r_bresp;
    logic [C_S_AXI_ID_WIDTH-1:0] r_bid;

    r_state_t                    r_rstate;
    logic [AW-1:0]               r_raddr;
    logic [7:0]                  r_rlen;
    logic [7:0]                  r_rcnt;
    logic [1:0]                  r_rburst;
    logic                        r_rcfg_err;
    logic                        r_arready;
    logic                        r_rvalid;
    logic                        r_rlast;
    logic [1:0]                  r_rresp;
    logic [DW-1:0]               r_rdata;
    logic [C_S_AXI_ID_WIDTH-1:0] r_rid;

    logic          w_wbeat;
    logic          w_wbeat_last;
    logic          w_wlast_bad;
    logic [AW-1:0] w_wnext_addr;
    logic [AW-1:0] w_rnext_addr;
    logic [DW-1:0] w_rdata_next;

    assign w_wbeat      = r_wready && S_AXI_WVALID;
    assign w_wbeat_last = (r_wcnt == r_wlen);
    assign w_wlast_bad  = (S_AXI_WLAST != w_wbeat_last);
    assign w_wnext_addr = f_next_addr(r_waddr, r_wburst, r_wlen);
    assign w_rnext_addr = f_next_addr(r_raddr, r_rburst, r_rlen);
    assign w_rdata_next = r_rcfg_err ? '0 : r_mem[w_rnext_addr[AW-1:2]];

    // RAM is never reset; a beat landing on a reset edge is dropped.
    always_ff @(posedge ACLK) begin
        if (ARESETN && w_wbeat && !r_wcfg_err) begin
            for (int b = 0; b < DW / 8; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    r_mem[r_waddr[AW-1:2]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_wstate    <= W_IDLE;
            r_waddr     <= '0;
            r_wlen      <= '0;
            r_wcnt      <= '0;
            r_wburst    <= '0;
            r_wcfg_err  <= 1'b0;
            r_wlast_err <= 1'b0;
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bresp     <= RESP_OKAY;
            r_bid       <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    if (r_awready && S_AXI_AWVALID) begin
                        r_awready   <= 1'b0;
                        r_wready    <= 1'b1;
                        r_bid       <= S_AXI_AWID;
                        r_waddr     <= S_AXI_AWADDR;
                        r_wlen      <= S_AXI_AWLEN;
                        r_wburst    <= S_AXI_AWBURST;
                        r_wcfg_err  <= f_cfg_err(S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWLEN);
                        r_wlast_err <= 1'b0;
                        r_wcnt      <= '0;
                        r_wstate    <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_wbeat) begin
                        r_waddr <= w_wnext_addr;
                        r_wcnt  <= r_wcnt + 8'd1;
                        if (w_wlast_bad) begin
                            r_wlast_err <= 1'b1;
                        end
                        // Burst length comes from AWLEN; WLAST only flags a protocol error.
                        if (w_wbeat_last) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_wcfg_err || r_wlast_err || w_wlast_bad) ? RESP_SLVERR : RESP_OKAY;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_rstate   <= R_IDLE;
            r_raddr    <= '0;
            r_rlen     <= '0;
            r_rcnt     <= '0;
            r_rburst   <= '0;
            r_rcfg_err <= 1'b0;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
            r_rresp    <= RESP_OKAY;
            r_rdata    <= '0;
            r_rid      <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (r_arready && S_AXI_ARVALID) begin
                        r_arready  <= 1'b0;
                        r_rid      <= S_AXI_ARID;
                        r_raddr    <= S_AXI_ARADDR;
                        r_rlen     <= S_AXI_ARLEN;
                        r_rburst   <= S_AXI_ARBURST;
                        r_rcfg_err <= f_cfg_err(S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARLEN);
                        r_rcnt     <= '0;
                        r_rstate   <= R_LOAD;
                    end
                end
                R_LOAD: begin
                    r_rdata  <= r_rcfg_err ? '0 : r_mem[r_raddr[AW-1:2]];
                    r_rresp  <= r_rcfg_err ? RESP_SLVERR : RESP_OKAY;
                    r_rlast  <= (r_rlen == 8'd0);
                    r_rvalid <= 1'b1;
                    r_rstate <= R_DATA;
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            // Prefetch the next word on the accepting edge for one beat per cycle.
                            r_raddr <= w_rnext_addr;
                            r_rcnt  <= r_rcnt + 8'd1;
                            r_rdata <= w_rdata_next;
                            r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_BID     = r_bid;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RLAST   = r_rlast;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RID     = r_rid;

endmodule

// File: tb/tb_sampler_axi4_mem_slave.sv
// Directed bench for sampler_axi4_mem_slave: a table of bursts with hand-computed results,
// then hand sequences for RREADY stalls and reset in the middle of a write burst.
module tb_sampler_axi4_mem_slave;
    localparam int TMO = 100;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

    typedef struct {
        bit                wr;
        logic [0:0]        id;
        logic [9:0]        addr;
        logic [7:0]        len;
        logic [1:0]        burst;
        logic [2:0]        size;
        logic [3:0]        strb;
        bit                bad_last;
        logic [1:0]        resp;
        logic [7:0][31:0]  dat;   // write data, or expected read data
    } vec_t;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [0:0]  awid, arid, bid, rid;
    logic [9:0]  awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    sampler_axi4_mem_slave dut (
        .ACLK(clk), .ARESETN(aresetn),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
        .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
        .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timeout after %0d cycles", nm, TMO);
    endtask

    function automatic vec_t mk(input bit wr, input logic [0:0] id, input logic [9:0] addr,
                                input logic [7:0] len, input logic [1:0] burst, input logic [2:0] size,
                                input logic [3:0] strb, input bit bad, input logic [1:0] resp,
                                input logic [31:0] d0 = 0, input logic [31:0] d1 = 0,
                                input logic [31:0] d2 = 0, input logic [31:0] d3 = 0,
                                input logic [31:0] d4 = 0, input logic [31:0] d5 = 0,
                                input logic [31:0] d6 = 0, input logic [31:0] d7 = 0);
        vec_t v;
        v.wr = wr; v.id = id; v.addr = addr; v.len = len; v.burst = burst; v.size = size;
        v.strb = strb; v.bad_last = bad; v.resp = resp;
        v.dat[0] = d0; v.dat[1] = d1; v.dat[2] = d2; v.dat[3] = d3;
        v.dat[4] = d4; v.dat[5] = d5; v.dat[6] = d6; v.dat[7] = d7;
        return v;
    endfunction

    // abort_at > 0 pulses reset right after that many beats and abandons the burst.
    task automatic do_write(input int idx, input vec_t v, input int abort_at);
        int  t, lat;
        bit  hs;
        awid = v.id; awaddr = v.addr; awlen = v.len; awburst = v.burst; awsize = v.size;
        awvalid = 1'b1;
        t = 0;
        do begin hs = awready; @(posedge clk); #1; t++; end while (!hs && t < TMO);
        awvalid = 1'b0;
        if (!hs) begin tmo($sformatf("v%0d_aw", idx)); return; end
        chk($sformatf("v%0d_awready_busy", idx), awready, 0);
        chk($sformatf("v%0d_wready_open", idx), wready, 1);
        lat = 0;
        for (int b = 0; b <= int'(v.len); b++) begin
            wvalid = 1'b1; wdata = v.dat[b]; wstrb = v.strb;
            wlast = v.bad_last ? (b == 0) : (b == int'(v.len));
            t = 0;
            do begin hs = wready; @(posedge clk); #1; lat++; t++; end while (!hs && t < TMO);
            if (!hs) begin wvalid = 1'b0; tmo($sformatf("v%0d_w%0d", idx, b)); return; end
            if (b + 1 == abort_at) begin
                wvalid = 1'b0; wlast = 1'b0;
                aresetn = 1'b0;
                @(posedge clk); #1;
                chk($sformatf("v%0d_rst_wready", idx), wready, 0);
                chk($sformatf("v%0d_rst_awready", idx), awready, 0);
                aresetn = 1'b1;
                @(posedge clk); #1;
                chk($sformatf("v%0d_rel_awready", idx), awready, 1);
                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("v%0d_no_bvalid%0d", idx, k), bvalid, 0);
                    @(posedge clk); #1;
                end
                return;
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        t = 0;
        while (!bvalid && t < TMO) begin @(posedge clk); #1; lat++; t++; end
        if (!bvalid) begin tmo($sformatf("v%0d_bvalid", idx)); return; end
        // AW on edge n, beats on n+1..n+1+L, BVALID visible right after edge n+1+L.
        chk($sformatf("v%0d_b_latency", idx), lat, int'(v.len) + 1);
        chk($sformatf("v%0d_bid", idx), bid, v.id);
        chk($sformatf("v%0d_bresp", idx), bresp, v.resp);
        repeat (2) begin @(posedge clk); #1; end
        chk($sformatf("v%0d_bvalid_hold", idx), bvalid, 1);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        chk($sformatf("v%0d_bvalid_clr", idx), bvalid, 0);
        chk($sformatf("v%0d_awready_back", idx), awready, 1);
    endtask

    task automatic do_read(input int idx, input vec_t v, input bit toggle);
        int t, beat;
        bit hs;
        arid = v.id; araddr = v.addr; arlen = v.len; arburst = v.burst; arsize = v.size;
        arvalid = 1'b1;
        t = 0;
        do begin hs = arready; @(posedge clk); #1; t++; end while (!hs && t < TMO);
        arvalid = 1'b0;
        if (!hs) begin tmo($sformatf("v%0d_ar", idx)); return; end
        chk($sformatf("v%0d_arready_busy", idx), arready, 0);
        chk($sformatf("v%0d_rload_gap", idx), rvalid, 0);
        beat = 0;
        t = 0;
        while (beat <= int'(v.len) && t < TMO) begin
            rready = toggle ? (t % 2 == 0) : 1'b1;
            if (t == 1) chk($sformatf("v%0d_rvalid_lat", idx), rvalid, 1);
            if (rvalid) begin
                chk($sformatf("v%0d_rdata%0d", idx, beat), rdata, v.dat[beat]);
                chk($sformatf("v%0d_rlast%0d", idx, beat), rlast, beat == int'(v.len));
                chk($sformatf("v%0d_rresp%0d", idx, beat), rresp, v.resp);
                chk($sformatf("v%0d_rid%0d", idx, beat), rid, v.id);
                if (rready) beat++;
            end
            @(posedge clk); #1;
            t++;
        end
        rready = 1'b0;
        if (beat <= int'(v.len)) begin tmo($sformatf("v%0d_rbeats", idx)); return; end
        chk($sformatf("v%0d_rvalid_clr", idx), rvalid, 0);
        chk($sformatf("v%0d_arready_back", idx), arready, 1);
    endtask

    initial begin
        #(200_000);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;

        //          wr id addr    len burst sz strb bad resp   data / expected read data
        tbl.push_back(mk(1, 0, 10'h000, 7, INCR,  2, 4'hF, 0, OKAY,   1, 2, 3, 4, 5, 6, 7, 8));
        tbl.push_back(mk(0, 0, 10'h000, 7, INCR,  2, 4'h0, 0, OKAY,   1, 2, 3, 4, 5, 6, 7, 8));
        tbl.push_back(mk(1, 1, 10'h010, 0, INCR,  2, 4'hF, 0, OKAY,   32'hAABBCCDD));
        tbl.push_back(mk(1, 0, 10'h010, 0, INCR,  2, 4'h5, 0, OKAY,   32'h11223344));
        tbl.push_back(mk(0, 1, 10'h010, 0, INCR,  2, 4'h0, 0, OKAY,   32'hAA22CC44));
        tbl.push_back(mk(1, 1, 10'h008, 3, WRAP,  2, 4'hF, 0, OKAY,   32'hA, 32'hB, 32'hC, 32'hD));
        tbl.push_back(mk(0, 0, 10'h000, 3, INCR,  2, 4'h0, 0, OKAY,   32'hC, 32'hD, 32'hA, 32'hB));
        tbl.push_back(mk(1, 0, 10'h000, 1, RSVD,  2, 4'hF, 0, SLVERR, 32'hDEAD0001, 32'hDEAD0002));
        tbl.push_back(mk(0, 0, 10'h000, 1, INCR,  2, 4'h0, 0, OKAY,   32'hC, 32'hD));
        tbl.push_back(mk(0, 1, 10'h000, 2, INCR,  1, 4'h0, 0, SLVERR, 0, 0, 0));
        tbl.push_back(mk(1, 0, 10'h000, 2, WRAP,  2, 4'hF, 0, SLVERR, 32'hBAD0, 32'hBAD1, 32'hBAD2));
        tbl.push_back(mk(0, 0, 10'h000, 2, FIXED, 2, 4'h0, 0, OKAY,   32'hC, 32'hC, 32'hC));
        tbl.push_back(mk(1, 1, 10'h040, 2, FIXED, 2, 4'hF, 0, OKAY,   5, 6, 7));
        tbl.push_back(mk(0, 1, 10'h040, 0, INCR,  2, 4'h0, 0, OKAY,   7));
        tbl.push_back(mk(1, 0, 10'h3FC, 1, INCR,  2, 4'hF, 0, OKAY,   32'h11, 32'h22));
        tbl.push_back(mk(0, 0, 10'h3FC, 1, INCR,  2, 4'h0, 0, OKAY,   32'h11, 32'h22));
        tbl.push_back(mk(1, 1, 10'h020, 1, INCR,  2, 4'hF, 1, SLVERR, 32'h31, 32'h32));
        tbl.push_back(mk(1, 0, 10'h200, 7, INCR,  2, 4'hF, 0, OKAY,
                         32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h106, 32'h107));
        tbl.push_back(mk(1, 1, 10'h024, 3, WRAP,  2, 4'hF, 0, OKAY,   32'h41, 32'h42, 32'h43, 32'h44));
        tbl.push_back(mk(0, 1, 10'h020, 3, INCR,  2, 4'h0, 0, OKAY,   32'h44, 32'h41, 32'h42, 32'h43));
        tbl.push_back(mk(0, 0, 10'h02C, 3, WRAP,  2, 4'h0, 0, OKAY,   32'h43, 32'h44, 32'h41, 32'h42));

        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_bid", bid, 0);
        chk("rst_arready", arready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rid", rid, 0);
        chk("rst_rdata", rdata, 0);
        aresetn = 1'b1;
        @(posedge clk); #1;
        chk("rel_awready", awready, 1);
        chk("rel_arready", arready, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].wr) do_write(i, tbl[i], 0);
            else           do_read(i, tbl[i], 1'b0);
        end

        // RREADY toggling: data must hold through every stall cycle.
        do_read(100, mk(0, 1, 10'h200, 7, INCR, 2, 4'h0, 0, OKAY,
                        32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h106, 32'h107), 1'b1);

        // Reset after beat 3 of an 8-beat write; the first three beats stay in memory.
        do_write(101, mk(1, 0, 10'h300, 7, INCR, 2, 4'hF, 0, OKAY,
                         32'h300, 32'h301, 32'h302, 32'h303, 32'h304, 32'h305, 32'h306, 32'h307), 3);
        do_write(102, mk(1, 1, 10'h380, 1, INCR, 2, 4'hF, 0, OKAY, 32'h55, 32'h66), 0);
        do_read(103, mk(0, 0, 10'h300, 2, INCR, 2, 4'h0, 0, OKAY, 32'h300, 32'h301, 32'h302), 1'b0);
        do_read(104, mk(0, 1, 10'h380, 1, INCR, 2, 4'h0, 0, OKAY, 32'h55, 32'h66), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sampler_axi4_mem_slave.md
# sampler_axi4_mem_slave

AXI4 (full) memory-mapped slave answering the burst write/read traffic issued by the Sampler master VIP agent on the S00_AXI port. It holds a small word-addressed register memory, accepts INCR/FIXED/WRAP bursts of up to 256 beats, echoes transaction IDs, and returns OKAY or SLVERR responses. It sits behind the block-design interconnect as the responder end of the master agent's WRITE_BURST/READ_BURST sequences.

## Interface
- C_S_AXI_ID_WIDTH, 1: width of AWID/BID/ARID/RID.
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 10: byte-address width; memory depth = 2^(C_S_AXI_ADDR_WIDTH-2) words (256).
- ACLK  in  1  single clock; all logic on rising edge.
- ARESETN  in  1  synchronous, active-low reset.
- S_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID/ADDR/8/3/2  write address channel.
- S_AXI_AWVALID in 1, S_AXI_AWREADY out 1: write address handshake.
- S_AXI_WDATA/WSTRB/WLAST  in  32/4/1  write data.
- S_AXI_WVALID in 1, S_AXI_WREADY out 1: write data handshake.
- S_AXI_BID/BRESP out ID/2, S_AXI_BVALID out 1, S_AXI_BREADY in 1: write response.
- S_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID/ADDR/8/3/2  read address channel.
- S_AXI_ARVALID in 1, S_AXI_ARREADY out 1: read address handshake.
- S_AXI_RID/RDATA/RRESP/RLAST out ID/32/2/1, S_AXI_RVALID out 1, S_AXI_RREADY in 1: read data.
- LOCK/CACHE/PROT/QOS/REGION/USER signals are not ports; interconnect ties them off.

## Operation
- Write and read paths are independent FSMs; one outstanding transaction each.
- Write FSM: W_IDLE (AWREADY=1) -> on AW handshake latch id, addr, len, burst, size; beat counter=0 -> W_DATA (WREADY=1). Each W handshake writes bytes enabled by WSTRB to mem[addr[ADDR-1:2]], advances address, increments counter. Beat with counter==len -> W_RESP (BVALID=1, BID=latched id). BVALID&BREADY -> W_IDLE.
- WLAST is ignored for beat counting; the burst ends on counter==len. If WLAST disagrees with counter==len on any beat, BRESP=SLVERR.
- Read FSM: R_IDLE (ARREADY=1) -> AR handshake latches fields -> R_LOAD (one cycle, RDATA<=mem[addr]) -> R_DATA (RVALID=1, RID=latched id, RLAST=(counter==len)). On RVALID&RREADY: if last -> R_IDLE, else advance address and load RDATA with next word same edge (1 beat/cycle sustained).
- Address update: FIXED keeps address; INCR adds 4, wrapping modulo memory size (upper address bits ignored); WRAP adds 4 within a (len+1)*4-byte aligned window: next = (addr & ~(W-1)) | ((addr+4) & (W-1)).
- Errors (SLVERR): size != 2, burst == 2'b11, or WRAP with len not in {1,3,7,15}. Erroneous write: all beats accepted, memory untouched, BRESP=SLVERR. Erroneous read: full len+1 beats returned, RDATA=0, RRESP=SLVERR every beat. Otherwise RESP=OKAY.
- Same-word read and write on the same edge: RDATA captures pre-write contents.
- Memory contents are not cleared by reset.

## Timing
- Reset (ARESETN=0 at rising edge): AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST=0; BRESP, RRESP=0; BID, RID, RDATA=0; FSMs to idle. AWREADY and ARREADY go 1 on the first edge after reset release.
- Reset mid-burst aborts the transaction; no response issued; partially written beats remain in memory.
- AW handshake at edge n -> WREADY high from n+1; last W beat at edge m -> BVALID high from m+1; BVALID held until BREADY.
- AR handshake at edge n -> R_LOAD in cycle n+1 -> RVALID high from n+2. RDATA/RLAST/RRESP stable while RVALID=1 and RREADY=0.
- AWREADY=0 outside W_IDLE; ARREADY=0 outside R_IDLE. Write latency from AW to BVALID for len L with no WVALID stalls: L+2 cycles.

## Test plan
- INCR write id0, addr 0x0, len 7, data 1..8, WSTRB 0xF -> BRESP OKAY, BID 0; INCR read same -> RDATA 1..8, RLAST only on beat 8, RID 0.
- Write 0xAABBCCDD to 0x10 then WSTRB 0x5 with 0x11223344 -> readback 0xAA22CC44.
- WRAP write len 3 at 0x8, data A,B,C,D -> mem[0x8]=A, 0xC=B, 0x0=C, 0x4=D; INCR read at 0x0 len 3 returns C,D,A,B.
- Read len 7 with RREADY toggling 1/0 each cycle -> RDATA held during stalls, 8 beats, data unchanged from write.
- AWBURST 2'b11, len 1 -> two W beats accepted, BRESP SLVERR, memory unchanged; ARSIZE=1 read len 2 -> 3 beats RRESP SLVERR, RDATA 0.
- ARESETN low for one cycle after beat 3 of an 8-beat write -> no BVALID, AWREADY=1 after release; new burst completes with OKAY.
